// File: rtl/sd_spi_pkg.sv
// Shared constants for the SD card SPI master: port offsets, FSM states,
// STATUS bit positions and the idle levels of the SPI pins.
package sd_spi_pkg;

  localparam int unsigned OFF_DATA = 0;
  localparam int unsigned OFF_CTRL = 1;
  localparam int unsigned OFF_DIV  = 2;

  localparam int unsigned BIT_BUSY = 7;
  localparam int unsigned BIT_DET  = 6;
  localparam int unsigned BIT_MISO = 5;
  localparam int unsigned BIT_OVR  = 4;
  localparam int unsigned BIT_SSEL = 0;

  localparam logic SCK_IDLE    = 1'b0;
  localparam logic MOSI_IDLE   = 1'b1;
  localparam logic SSEL_N_IDLE = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_e;

endpackage

// File: rtl/sd_spi_halfper.sv
// Half-period timer for SCK: counts div+1 phi cycles while enabled and pulses
// expire on the last one, reloading itself so consecutive half-periods chain.
module sd_spi_halfper (
  input  logic       phi,
  input  logic       reset,
  input  logic       load,
  input  logic       en,
  input  logic [7:0] div,
  output logic       expire
);

  logic [7:0] cnt_q;

  assign expire = en && (cnt_q == 8'd0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge phi) begin
    if (reset) begin
      cnt_q <= 8'd0;
    end else if (load || expire) begin
      cnt_q <= div;
    end else if (en) begin
      cnt_q <= cnt_q - 8'd1;
    end
  end

endmodule

// File: rtl/sd_spi_ctrl.sv
// Byte-wide SPI master (mode 0, MSB first) for the SD card slot, mapped as DATA/CTRL/DIV ports.
// Define SD_SPI_IRQ_EN to build the transfer-complete interrupt flop; otherwise irq is tied low.
module sd_spi_ctrl
  import sd_spi_pkg::*;
#(
  parameter logic [7:0] DIV_RESET = 8'd11,
  parameter int         ADDR_W    = 2
) (
  input  logic              phi,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_wr_tick,
  input  logic              cpu_rd_tick,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  input  logic              sd_miso,
  input  logic              sd_det,
  output logic              sd_mosi,
  output logic              sd_clk,
  output logic              sd_ssel_n,
  output logic              irq
);

  state_e     state_q, state_d;
  logic       busy_q, overrun_q;
  logic [7:0] div_q, tx_q, rx_shift_q, rx_data_q, status;
  logic [2:0] bit_cnt_q;
  logic       sel_data, sel_ctrl, sel_div;
  logic       rd_side, wr_data, start;
  logic       hp_load, hp_en, expire, last_bit, done;

  assign sel_data = (cpu_addr == ADDR_W'(OFF_DATA));
  assign sel_ctrl = (cpu_addr == ADDR_W'(OFF_CTRL));
  assign sel_div  = (cpu_addr == ADDR_W'(OFF_DIV));

  // A write on the same tick as a read wins; the read's clear-on-read effect is dropped.
  assign rd_side  = cpu_rd_tick & ~cpu_wr_tick;
  assign wr_data  = cpu_wr_tick & sel_data;
  assign start    = wr_data & ~busy_q;

  assign hp_load  = (state_q == IDLE) & busy_q;
  assign hp_en    = (state_q != IDLE);
  assign last_bit = (bit_cnt_q == 3'd7);
  assign done     = (state_q == HIGH) & expire & last_bit;

  sd_spi_halfper u_halfper (
    .phi    (phi),
    .reset  (reset),
    .load   (hp_load),
    .en     (hp_en),
    .div    (div_q),
    .expire (expire)
  );

  always_ff @(posedge phi) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (busy_q) state_d = LOW;
      LOW:     if (expire) state_d = HIGH;
      HIGH:    if (expire) state_d = last_bit ? IDLE : LOW;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge phi) begin
    if (reset) begin
      sd_clk     <= SCK_IDLE;
      sd_mosi    <= MOSI_IDLE;
      sd_ssel_n  <= SSEL_N_IDLE;
      div_q      <= DIV_RESET;
      tx_q       <= 8'hFF;
      rx_shift_q <= 8'hFF;
      rx_data_q  <= 8'hFF;
      bit_cnt_q  <= 3'd0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      if (start) begin
        tx_q      <= cpu_din;
        bit_cnt_q <= 3'd0;
        busy_q    <= 1'b1;
      end

      if (wr_data && busy_q)            overrun_q <= 1'b1;
      else if (rd_side && sel_ctrl)     overrun_q <= 1'b0;

      if (cpu_wr_tick && sel_ctrl && !busy_q) sd_ssel_n <= ~cpu_din[0];
      if (cpu_wr_tick && sel_div && !busy_q)  div_q     <= cpu_din;

      case (state_q)
        IDLE: if (busy_q) sd_mosi <= tx_q[7];
        LOW: if (expire) begin
          sd_clk     <= 1'b1;
          rx_shift_q <= {rx_shift_q[6:0], sd_miso};
        end
        HIGH: if (expire) begin
          sd_clk <= 1'b0;
          if (last_bit) begin
            rx_data_q <= rx_shift_q;
            busy_q    <= 1'b0;
            sd_mosi   <= MOSI_IDLE;
          end else begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
            tx_q      <= {tx_q[6:0], 1'b0};
            sd_mosi   <= tx_q[6];
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    status           = 8'h00;
    status[BIT_BUSY] = busy_q;
    status[BIT_DET]  = sd_det;
    status[BIT_MISO] = sd_miso;
    status[BIT_OVR]  = overrun_q;
    status[BIT_SSEL] = ~sd_ssel_n;
  end

  always_comb begin
    cpu_dout = 8'hFF;
    if (sel_data)      cpu_dout = rx_data_q;
    else if (sel_ctrl) cpu_dout = status;
    else if (sel_div)  cpu_dout = div_q;
  end

`ifdef SD_SPI_IRQ_EN
  logic irq_q;

  always_ff @(posedge phi) begin
    if (reset)                                irq_q <= 1'b0;
    else if (done)                            irq_q <= 1'b1;
    else if (wr_data || (rd_side && sel_data)) irq_q <= 1'b0;
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule
